ram_sp_arbiter: RTL
===================

RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of RAM words; localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have port clock  input  1  single clock; all state on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for N in {0,1}: reqN_valid  input  1  request present.
REQ-006 SHALL have reqN_ready  output  1  request accepted this cycle.
REQ-007 SHALL have reqN_wen  input  1  1 = write, 0 = read.
REQ-008 SHALL have reqN_bwen  input  DATA_WIDTH  per-bit write mask; 1 = bit written.
REQ-009 SHALL have reqN_addr  input  ADDR_WIDTH  word address.
REQ-010 SHALL have reqN_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have rspN_valid  output  1  read data for port N valid this cycle.
REQ-012 SHALL have rspN_rdata  output  DATA_WIDTH  read data for port N.
REQ-013 SHALL have ram_cen, ram_wen  output  1 each, and ram_bwen, ram_din  output  DATA_WIDTH, and ram_addr  output  ADDR_WIDTH; these drive the single-port bit-masked RAM.
REQ-014 SHALL have ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after the RAM samples a read.

Function
REQ-015 SHALL accept at most one request per cycle; a handshake on port N is reqN_valid && reqN_ready at a clock edge.
REQ-016 SHALL compute reqN_ready combinationally: only one valid -> that port ready; both valid -> port selected by priority pointer ready, other not; no valid -> both ready low.
REQ-017 SHALL keep a 1-bit round-robin priority pointer (0 = port 0 preferred); after every accepted request it points to the port that did not win.
REQ-018 SHALL leave the pointer unchanged in cycles with no accepted request.
REQ-019 SHALL register the accepted command at the handshake edge: ram_cen=1, ram_wen/ram_bwen/ram_addr/ram_din = winner's wen/bwen/addr/wdata.
REQ-020 SHALL drive ram_cen=0 in the cycle following any edge with no handshake; ram_wen, ram_bwen, ram_addr, ram_din then hold their previous values.
REQ-021 SHALL pipeline a read tag (valid, port id) alongside the registered command and advance it one more stage when the RAM samples the read.
REQ-022 SHALL assert rspN_valid for exactly one cycle, two cycles after the read handshake on port N, with rspN_rdata = ram_dout in that cycle.
REQ-023 SHALL drive rspN_rdata from ram_dout at all times; it is meaningful only when rspN_valid=1.
REQ-024 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.
REQ-025 SHALL generate no response for a write; write effect appears in RAM at the edge after the handshake edge.
REQ-026 SHALL sustain one accepted request per cycle back-to-back, including alternating read/write, with responses returned in acceptance order.
REQ-027 SHALL return, for a read accepted the cycle after a write to the same address, data including that write (RAM order preserved; no bypass needed).
REQ-028 SHALL provide no response backpressure; requesters must consume rspN at rspN_valid.

Reset
REQ-029 SHALL, while reset_n=0, immediately force ram_cen=0, ram_wen=0, ram_bwen=0, ram_addr=0, ram_din=0, priority pointer=0, all read tags invalid, so rsp0_valid=rsp1_valid=0.
REQ-030 SHALL drop any in-flight read whose tag is cleared by reset; no response is produced after reset deasserts.
REQ-031 SHALL keep reqN_ready low while reset_n=0.

Verification
REQ-032 Port 0 write addr 3, wdata 0xA5A5A5A5, bwen 0xFFFFFFFF; then port 0 read addr 3 -> rsp0_valid 2 cycles after read handshake, rsp0_rdata=0xA5A5A5A5.
REQ-033 Prior word 0xA5A5A5A5 at addr 3; port 1 write wdata 0x12345678, bwen 0x0000FFFF; port 1 read addr 3 -> rsp1_rdata=0xA5A55678.
REQ-034 Both ports hold valid reads (addr 1, addr 2) for 4 cycles after reset -> grants 0,1,0,1; responses rsp0,rsp1,rsp0,rsp1 on consecutive cycles.
REQ-035 Port 1 alone valid 3 cycles, then both valid -> port 1 accepted 3 times, then port 0 wins first contended cycle.
REQ-036 reset_n pulsed low one cycle after a port 0 read handshake -> ram_cen=0 asynchronously, no rsp0_valid afterwards, pointer=0.
REQ-037 Port 0 write addr 5 then port 1 read addr 5 on next cycle -> rsp1_rdata equals newly written data.

Source files
------------

// File: rtl/ram_sp_arbiter_if.sv
// Requester-side bundle for the two-port RAM arbiter: request handshakes and read responses.
interface ram_sp_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_wen;
    logic [DATA_WIDTH-1:0] req0_bwen;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_wen;
    logic [DATA_WIDTH-1:0] req1_bwen;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    // Requesters drive requests and consume responses.
    modport master (
        output req0_valid, req0_wen, req0_bwen, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_wen, req1_bwen, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    // The arbiter accepts requests and returns read data.
    modport slave (
        input  req0_valid, req0_wen, req0_bwen, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_wen, req1_bwen, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port bit-masked RAM between two requesters.
// Accepted commands are registered onto the RAM pins; reads return two cycles after handshake.
module ram_sp_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    ram_sp_arbiter_if.slave                  bus,
    output logic                             ram_cen,
    output logic                             ram_wen,
    output logic [DATA_WIDTH-1:0]            ram_bwen,
    output logic [DATA_WIDTH-1:0]            ram_din,
    output logic [$clog2(DEPTH)-1:0]         ram_addr,
    input  logic [DATA_WIDTH-1:0]            ram_dout
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    // Registered RAM command
    logic                  cen_q,  cen_d;
    logic                  wen_q,  wen_d;
    logic [DATA_WIDTH-1:0] bwen_q, bwen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q,  din_d;

    // Priority pointer: 0 prefers port 0 on contention
    logic                  ptr_q, ptr_d;

    // Read tag riding with the command, then with the RAM read cycle
    logic                  tag_vld_q, tag_vld_d;
    logic                  tag_id_q,  tag_id_d;
    logic                  rsp0_vld_q, rsp0_vld_d;
    logic                  rsp1_vld_q, rsp1_vld_d;

    logic                  ready0_c, ready1_c;
    logic                  hs_c;
    logic                  sel_wen_c;
    logic [DATA_WIDTH-1:0] sel_bwen_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;

    // Grant decision: a lone requester wins, contention goes to the pointer; nothing during reset
    always_comb begin
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        if (reset_n) begin
            ready0_c = bus.req0_valid && (!bus.req1_valid || !ptr_q);
            ready1_c = bus.req1_valid && (!bus.req0_valid ||  ptr_q);
        end
    end

    // Winner's command fields; ready1_c set means port 1 won this cycle
    always_comb begin
        hs_c        = (bus.req0_valid && ready0_c) || (bus.req1_valid && ready1_c);
        sel_wen_c   = bus.req0_wen;
        sel_bwen_c  = bus.req0_bwen;
        sel_addr_c  = bus.req0_addr;
        sel_wdata_c = bus.req0_wdata;
        if (ready1_c) begin
            sel_wen_c   = bus.req1_wen;
            sel_bwen_c  = bus.req1_bwen;
            sel_addr_c  = bus.req1_addr;
            sel_wdata_c = bus.req1_wdata;
        end
    end

    // Next-state: load command on handshake, otherwise idle the RAM and hold the data pins
    always_comb begin
        cen_d      = 1'b0;
        wen_d      = wen_q;
        bwen_d     = bwen_q;
        addr_d     = addr_q;
        din_d      = din_q;
        ptr_d      = ptr_q;
        tag_vld_d  = 1'b0;
        tag_id_d   = tag_id_q;
        rsp0_vld_d = tag_vld_q && !tag_id_q;
        rsp1_vld_d = tag_vld_q &&  tag_id_q;
        if (hs_c) begin
            cen_d     = 1'b1;
            wen_d     = sel_wen_c;
            bwen_d    = sel_bwen_c;
            addr_d    = sel_addr_c;
            din_d     = sel_wdata_c;
            ptr_d     = !ready1_c;
            tag_vld_d = !sel_wen_c;
            tag_id_d  = ready1_c;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            bwen_q     <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            ptr_q      <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_id_q   <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
        end else begin
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            bwen_q     <= bwen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            ptr_q      <= ptr_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
        end
    end

    assign ram_cen        = cen_q;
    assign ram_wen        = wen_q;
    assign ram_bwen       = bwen_q;
    assign ram_addr       = addr_q;
    assign ram_din        = din_q;

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.rsp0_valid = rsp0_vld_q;
    assign bus.rsp1_valid = rsp1_vld_q;
    assign bus.rsp0_rdata = ram_dout;
    assign bus.rsp1_rdata = ram_dout;

endmodule
